// File: rtl/spram_arbiter_if.sv
// spram_arbiter_if -- bundle of all bus signals around the single-port RAM arbiter.
//   clear/busy                   : clear-sweep request pulse and sweep-in-progress flag
//   cpu_cs/we/addr/din, cpu_dout : primary CPU access, read data is the raw RAM q
//   dma_req/we/addr/din          : secondary (hiscore/debug) access request
//   dma_ack/dma_dout             : one-cycle completion strobe and registered read data
//   ram_enable/wren/address/data : single-port RAM drive
//   ram_q                        : RAM output (1-cycle registered read, write-through)
// Modport slave is the arbiter's view; master is the surrounding system
// (CPU, DMA source and the RAM itself).
interface spram_arbiter_if #(
  parameter int address_width = 8,
  parameter int data_width    = 8
);
  logic                     clear;
  logic                     busy;

  logic                     cpu_cs;
  logic                     cpu_we;
  logic [address_width-1:0] cpu_addr;
  logic [data_width-1:0]    cpu_din;
  logic [data_width-1:0]    cpu_dout;

  logic                     dma_req;
  logic                     dma_we;
  logic [address_width-1:0] dma_addr;
  logic [data_width-1:0]    dma_din;
  logic                     dma_ack;
  logic [data_width-1:0]    dma_dout;

  logic                     ram_enable;
  logic                     ram_wren;
  logic [address_width-1:0] ram_address;
  logic [data_width-1:0]    ram_data;
  logic [data_width-1:0]    ram_q;

  modport slave (
    input  clear, cpu_cs, cpu_we, cpu_addr, cpu_din,
    input  dma_req, dma_we, dma_addr, dma_din, ram_q,
    output busy, cpu_dout, dma_ack, dma_dout,
    output ram_enable, ram_wren, ram_address, ram_data
  );

  modport master (
    output clear, cpu_cs, cpu_we, cpu_addr, cpu_din,
    output dma_req, dma_we, dma_addr, dma_din, ram_q,
    input  busy, cpu_dout, dma_ack, dma_dout,
    input  ram_enable, ram_wren, ram_address, ram_data
  );
endinterface

// File: rtl/spram_arbiter.sv
// spram_arbiter -- shares one single-port RAM between a CPU (absolute priority),
// a secondary DMA-style port and a clear engine that sweeps clear_value over
// every address.
//   clock : single clock, all state on the rising edge
//   reset : asynchronous, active-high; restarts a full clear sweep on release
//   bus   : spram_arbiter_if.slave carrying the CPU, DMA, clear and RAM signals
// DMA accesses take two cycles from grant to dma_ack: the grant cycle drives
// the RAM, the following DMA_WAIT cycle sees the registered RAM output and
// captures it into dma_dout on its exit edge.
module spram_arbiter #(
  parameter int                    address_width = 8,
  parameter int                    data_width    = 8,
  parameter logic [data_width-1:0] clear_value   = '0
) (
  input logic               clock,
  input logic               reset,
  spram_arbiter_if.slave    bus
);

  localparam logic [address_width-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    DMA_WAIT
  } state_t;

  state_t                   state_q, state_d;
  logic [address_width-1:0] cnt_q, cnt_d;
  logic                     clr_pend_q, clr_pend_d;
  logic                     dma_ack_q, dma_ack_d;
  logic [data_width-1:0]    dma_dout_q, dma_dout_d;

  logic                     busy;
  logic                     ram_enable;
  logic                     ram_wren;
  logic [address_width-1:0] ram_address;
  logic [data_width-1:0]    ram_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      clr_pend_q <= 1'b0;
      dma_ack_q  <= 1'b0;
      dma_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_pend_q <= clr_pend_d;
      dma_ack_q  <= dma_ack_d;
      dma_dout_q <= dma_dout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clr_pend_d  = clr_pend_q;
    dma_ack_d   = 1'b0;
    dma_dout_d  = dma_dout_q;
    busy        = 1'b0;
    ram_enable  = 1'b0;
    ram_wren    = 1'b0;
    ram_address = bus.cpu_addr;
    ram_data    = bus.cpu_din;

    unique case (state_q)
      CLEAR: begin
        busy        = 1'b1;
        ram_enable  = 1'b1;
        ram_wren    = 1'b1;
        ram_address = cnt_q;
        ram_data    = clear_value;
        // A new clear request restarts the sweep from address 0.
        if (bus.clear) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      IDLE: begin
        if (bus.cpu_cs) begin
          ram_enable = 1'b1;
          ram_wren   = bus.cpu_we;
        end
        // Clear (fresh or held over from a DMA) beats a DMA request. While
        // dma_ack is high the DMA source is still presenting the request it
        // was just acknowledged for, so it must not be granted again.
        if (bus.clear || clr_pend_q) begin
          clr_pend_d = 1'b0;
          state_d    = CLEAR;
        end else if (!bus.cpu_cs && bus.dma_req && !dma_ack_q) begin
          ram_enable  = 1'b1;
          ram_wren    = bus.dma_we;
          ram_address = bus.dma_addr;
          ram_data    = bus.dma_din;
          state_d     = DMA_WAIT;
        end
      end

      DMA_WAIT: begin
        if (bus.cpu_cs) begin
          ram_enable = 1'b1;
          ram_wren   = bus.cpu_we;
        end
        // ram_q still holds the DMA result here; a CPU access in this cycle
        // only changes it at the same edge that captures it.
        dma_ack_d  = 1'b1;
        dma_dout_d = bus.ram_q;
        state_d    = IDLE;
        if (bus.clear) begin
          clr_pend_d = 1'b1;
        end
      end

      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.busy        = busy;
  assign bus.cpu_dout    = bus.ram_q;
  assign bus.dma_ack     = dma_ack_q;
  assign bus.dma_dout    = dma_dout_q;
  assign bus.ram_enable  = ram_enable;
  assign bus.ram_wren    = ram_wren;
  assign bus.ram_address = ram_address;
  assign bus.ram_data    = ram_data;

endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter -- directed and random stimulus for spram_arbiter with a
// behavioural single-port RAM, a reference memory and expected-result queues
// for CPU reads and DMA completions.
module tb_spram_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;

  spram_arbiter_if #(.address_width(8), .data_width(8)) bus ();

  spram_arbiter #(
    .address_width(8),
    .data_width   (8),
    .clear_value  (8'h00)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Behavioural RAM: registered read, write-through q.
  logic [7:0] mem [256];
  logic [7:0] wr_log [$];
  logic       scramble = 1'b0;
  int         bad_wren = 0;

  always @(posedge clock) begin
    if (bus.ram_wren && !bus.ram_enable) bad_wren <= bad_wren + 1;
    if (scramble) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (bus.ram_enable) begin
      if (bus.ram_wren) begin
        mem[bus.ram_address] <= bus.ram_data;
        bus.ram_q            <= bus.ram_data;
        wr_log.push_back(bus.ram_address);
      end else begin
        bus.ram_q <= mem[bus.ram_address];
      end
    end
  end

  logic [7:0] ref_mem [256];
  logic [7:0] cpu_exp [$];
  logic [7:0] dma_exp [$];
  logic       rd_pend  = 1'b0;
  logic       dma_out  = 1'b0;
  logic       ack_seen = 1'b0;
  int         checks   = 0;
  int         errors   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and score whatever the DUT produced on that edge.
  task automatic cyc();
    @(posedge clock);
    #1;
    if (rd_pend) begin
      chk("cpu_dout", 32'(bus.cpu_dout), 32'(cpu_exp.pop_front()));
      rd_pend = 1'b0;
    end
    if (bus.dma_ack) begin
      chk("ack_has_req", 32'(dma_out), 1);
      if (dma_exp.size() > 0) chk("dma_dout", 32'(bus.dma_dout), 32'(dma_exp.pop_front()));
      dma_out     = 1'b0;
      ack_seen    = 1'b1;
      bus.dma_req = 1'b0;
    end
  endtask

  task automatic cpu_idle();
    bus.cpu_cs = 1'b0;
    bus.cpu_we = 1'b0;
  endtask

  task automatic cpu_rd(input logic [7:0] a);
    bus.cpu_cs   = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = a;
    cpu_exp.push_back(ref_mem[a]);
    rd_pend = 1'b1;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    bus.cpu_cs   = 1'b1;
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = a;
    bus.cpu_din  = d;
    ref_mem[a]   = d;
  endtask

  task automatic dma_start(input logic we, input logic [7:0] a, input logic [7:0] d);
    bus.dma_req  = 1'b1;
    bus.dma_we   = we;
    bus.dma_addr = a;
    bus.dma_din  = d;
    if (we) ref_mem[a] = d;
    dma_exp.push_back(ref_mem[a]);
    dma_out  = 1'b1;
    ack_seen = 1'b0;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    while (!ack_seen && lat < 400) begin
      cyc();
      lat++;
    end
    chk("dma_ack_seen", 32'(ack_seen), 1);
  endtask

  // Call at the first sample of a sweep (state CLEAR, counter 0).
  task automatic sweep(input string tag);
    int n;
    int base;
    int bad;
    base = wr_log.size();
    n    = 0;
    while (bus.busy && n < 400) begin
      cyc();
      n++;
    end
    chk({tag, "_cycles"}, n, 256);
    chk({tag, "_writes"}, wr_log.size() - base, 256);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (wr_log[base + i] !== 8'(i)) bad++;
      if (mem[i] !== 8'h00) bad++;
      ref_mem[i] = 8'h00;
    end
    chk({tag, "_order_and_zero"}, bad, 0);
  endtask

  int         lat;
  int         n;
  int         dwait;
  logic [7:0] a;

  initial begin
    bus.clear    = 1'b0;
    bus.cpu_cs   = 1'b0;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_din  = '0;
    bus.dma_req  = 1'b0;
    bus.dma_we   = 1'b0;
    bus.dma_addr = '0;
    bus.dma_din  = '0;

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", 32'(bus.busy), 1);
    chk("rst_ack", 32'(bus.dma_ack), 0);
    chk("rst_dout", 32'(bus.dma_dout), 0);
    scramble = 1'b1;
    cyc();
    scramble = 1'b0;
    cyc();
    reset = 1'b0;
    sweep("sweep_init");
    cpu_rd(8'h00);
    cyc();
    cpu_rd(8'hFF);
    cyc();
    cpu_idle();

    // DMA write, two-cycle latency, write-through data, then CPU readback.
    dma_start(1'b1, 8'h10, 8'h3C);
    #1;
    chk("grant_addr", 32'(bus.ram_address), 'h10);
    chk("grant_wren", 32'(bus.ram_wren), 1);
    wait_ack(lat);
    chk("dma_latency", lat, 2);
    cyc();
    chk("ack_one_cycle", 32'(bus.dma_ack), 0);
    cpu_rd(8'h10);
    cyc();
    cpu_idle();

    // Reset in the middle of a sweep.
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    n = 0;
    while (bus.ram_address != 8'h80 && n < 300) begin
      cyc();
      n++;
    end
    chk("reach_0x80", 32'(bus.ram_address), 'h80);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 1);
    chk("mid_rst_ack", 32'(bus.dma_ack), 0);
    chk("mid_rst_dout", 32'(bus.dma_dout), 0);
    chk("mid_rst_addr", 32'(bus.ram_address), 0);
    cyc();
    cyc();
    reset = 1'b0;
    sweep("sweep_after_reset");

    // CPU hammering the RAM starves a pending DMA read until it lets go.
    cpu_wr(8'h20, 8'h55);
    dma_start(1'b0, 8'h20, 8'h00);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("cpu_prio_addr", 32'(bus.ram_address), 'h20);
      chk("cpu_prio_data", 32'(bus.ram_data), 'h55);
      cyc();
      chk("no_ack_while_cpu", 32'(ack_seen), 0);
    end
    cpu_idle();
    wait_ack(lat);
    chk("latency_after_cpu", lat, 2);

    // Clear during DMA_WAIT: the ack still arrives, the sweep follows.
    cpu_wr(8'h10, 8'hA7);
    cyc();
    cpu_idle();
    dma_start(1'b0, 8'h10, 8'h00);
    cyc();
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    chk("ack_before_clear", 32'(ack_seen), 1);
    chk("busy_during_ack", 32'(bus.busy), 0);
    cyc();
    chk("busy_after_ack", 32'(bus.busy), 1);
    sweep("sweep_after_dma");
    cpu_rd(8'h10);
    cyc();
    cpu_idle();

    // Clear and DMA together: clear wins; a second clear restarts the sweep.
    bus.clear = 1'b1;
    dma_start(1'b0, 8'h90, 8'h00);
    #1;
    chk("clear_beats_dma", 32'(bus.ram_enable), 0);
    cyc();
    bus.clear = 1'b0;
    chk("busy_on_clear", 32'(bus.busy), 1);
    repeat (10) cyc();
    chk("no_ack_while_busy", 32'(ack_seen), 0);
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    sweep("sweep_restart");
    wait_ack(lat);
    chk("latency_after_sweep", lat, 2);

    // Random CPU/DMA traffic; CPU owns 0x00-0x7F, DMA owns 0x80-0xFF.
    dwait = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(1, 0) == 1) begin
        a = 8'($urandom_range(127, 0));
        if ($urandom_range(1, 0) == 1) cpu_wr(a, 8'($urandom));
        else cpu_rd(a);
      end else begin
        cpu_idle();
      end
      if (!dma_out && $urandom_range(2, 0) == 0) begin
        dma_start(1'($urandom_range(1, 0)), 8'h80 | 8'($urandom_range(127, 0)), 8'($urandom));
        dwait = 0;
      end
      cyc();
      if (dma_out) begin
        dwait++;
        if (dwait > 60) begin
          chk("dma_lost", 32'(dma_out), 0);
          dma_out     = 1'b0;
          bus.dma_req = 1'b0;
          dma_exp.delete();
        end
      end
    end
    cpu_idle();
    if (dma_out) wait_ack(lat);
    cyc();
    chk("dma_queue_drained", dma_exp.size(), 0);
    chk("wren_without_enable", bad_wren, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
